proto_rx: RTL
=============

Name: proto_rx

Overview:
- Receive-side protocol decoder for the host link; mirror of the result transmitter.
- Consumes bytes from the UART receiver, parses host command frames, and delivers a checksummed mining job (block header) to the miner over a valid/ready handshake.
- Also decodes an ABORT command.
- Reports framing errors (bad command, checksum mismatch, inter-byte timeout) and overruns.

Parameters:
- HDR_BYTES, 80, header payload length in bytes (≥2).
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_valid  input  1  one-cycle strobe, rx_data holds a received byte
- rx_data  input  8  received byte
- job_ready  input  1  miner accepts job when high with job_valid
- job_valid  output  1  job_header holds a complete, checksum-verified job
- job_header  output  HDR_BYTES*8  job payload; first payload byte in bits [7:0]
- abort  output  1  one-cycle pulse on ABORT command
- err  output  1  one-cycle pulse on a framing error
- err_code  output  2  error cause, valid with err: 1 bad command, 2 checksum, 3 timeout
- overrun  output  1  one-cycle pulse when a byte is dropped because a job is pending

Behaviour:
- Frame formats:
  - NEW_JOB = 0x01, then HDR_BYTES payload bytes, then 1 checksum byte. The checksum is the XOR of all payload bytes.
  - ABORT = 0x02, single byte.
- All outputs are registered. On reset:
  - job_valid, abort, err, err_code, overrun = 0.
  - job_header = 0.
  - State = S_IDLE; byte counter, checksum and timeout counter cleared.
- Reset mid-frame discards the partial frame. Reset while job_valid is high drops the job.
- S_IDLE, on rx_valid:
  - 0x01 → S_PAYLOAD; count=0, csum=0.
  - 0x02 → abort pulses the following cycle; stay in S_IDLE.
  - Any other byte → err=1, err_code=1 the following cycle; stay.
- S_PAYLOAD, on rx_valid:
  - Write job_header[count*8 +: 8] = rx_data; csum ^= rx_data; count++.
  - After the byte with count == HDR_BYTES-1 → S_CSUM.
- S_CSUM, on rx_valid:
  - rx_data == csum → S_HOLD; job_valid=1 the following cycle.
  - Otherwise err=1, err_code=2 the following cycle; → S_IDLE; job_valid stays 0.
- Latency: job_valid rises exactly 1 cycle after the checksum byte strobe.
- S_HOLD:
  - job_valid=1 and job_header stable.
  - When job_ready=1 → S_IDLE; job_valid=0 the next cycle (transfer occurs on the cycle valid&ready).
  - job_header keeps its last value after transfer and is not cleared until overwritten by the next frame.
- Overrun: rx_valid in S_HOLD drops the byte and pulses overrun the next cycle; header unchanged. This includes 0x02, so ABORT is ignored while a job is pending. Simultaneous rx_valid and job_ready in S_HOLD: transfer completes, byte is still dropped, overrun pulses.
- Timeout: in S_PAYLOAD/S_CSUM a counter increments each cycle without rx_valid and clears on rx_valid. When it reaches TIMEOUT_CYCLES-1 with no byte:
  - → S_IDLE; err=1, err_code=3 the following cycle.
  - Counter cleared.
  - The partial payload in job_header is don't-care; job_valid stays 0.
  - The counter is inactive in S_IDLE/S_HOLD.
- err_code holds its last value when err=0. abort, err and overrun are never high for more than 1 cycle per event.
- Back-to-back bytes (rx_valid on consecutive cycles) are fully supported in every state.

Test Plan (HDR_BYTES=4, TIMEOUT_CYCLES=16):
- Good frame: bytes 01 11 22 33 44 44, job_ready=0 → job_valid rises 1 cycle after last byte; job_header=32'h44332211 stable for 10 cycles. Then job_ready=1 for 1 cycle → job_valid=0 next cycle.
- Bad checksum: 01 11 22 33 44 45 → single err pulse with err_code=2; job_valid never asserts. A following good frame is accepted.
- Commands: byte 02 → abort high exactly 1 cycle, no err. Byte 7F → err pulse, err_code=1. Neither changes job_valid.
- Timeout: 01 11 then silence → err pulse, err_code=3 at cycle 16 after the last byte. A complete frame sent immediately afterwards produces a job.
- Overrun: with a job pending, send 02 and AA → two overrun pulses, no abort, job_header unchanged. Then rx_valid and job_ready in the same cycle → job transferred, overrun pulses, state S_IDLE.
- Reset mid-frame: 01 11 22, then rst for 1 cycle → all outputs 0. Next full good frame 01 AA BB CC DD 00 yields job_header=32'hDDCCBBAA.

Source files
------------

// File: rtl/proto_rx_if.sv
// Host-link receive bus: UART byte strobe in, verified mining job and status pulses out.
// The master drives bytes and job_ready. The slave is the decoder.
interface proto_rx_if #(
  parameter int unsigned HDR_BYTES = 80
);
  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic                       job_ready;
  logic                       job_valid;
  logic [HDR_BYTES*8-1:0]     job_header;
  logic                       abort;
  logic                       err;
  logic [1:0]                 err_code;
  logic                       overrun;

  modport master (
    output rx_valid, rx_data, job_ready,
    input  job_valid, job_header, abort, err, err_code, overrun
  );

  modport slave (
    input  rx_valid, rx_data, job_ready,
    output job_valid, job_header, abort, err, err_code, overrun
  );
endinterface

// File: rtl/proto_rx.sv
// Host command frame decoder: parses NEW_JOB / ABORT frames, checks the XOR checksum,
// and holds a verified job header for the miner until it is accepted.
module proto_rx #(
  parameter int unsigned HDR_BYTES      = 80,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  proto_rx_if.slave   rx_bus
);
  localparam int unsigned CNT_W = $clog2(HDR_BYTES);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]       OP_JOB   = 8'h01;
  localparam logic [7:0]       OP_ABORT = 8'h02;
  localparam logic [1:0]       ERR_CMD  = 2'd1;
  localparam logic [1:0]       ERR_CSUM = 2'd2;
  localparam logic [1:0]       ERR_TMO  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HDR_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CSUM,
    S_HOLD
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [7:0]                 csum_q, csum_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [HDR_BYTES-1:0][7:0]  hdr_q, hdr_d;
  logic                       job_valid_q, job_valid_d;
  logic                       abort_q, abort_d;
  logic                       err_q, err_d;
  logic [1:0]                 err_code_q, err_code_d;
  logic                       overrun_q, overrun_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    hdr_d       = hdr_q;
    job_valid_d = job_valid_q;
    abort_d     = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rx_bus.rx_valid) begin
          if (rx_bus.rx_data == OP_JOB) begin
            state_d = S_PAYLOAD;
            cnt_d   = '0;
            csum_d  = '0;
          end else if (rx_bus.rx_data == OP_ABORT) begin
            abort_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CMD;
          end
        end
      end

      S_PAYLOAD: begin
        if (rx_bus.rx_valid) begin
          tmo_d        = '0;
          hdr_d[cnt_q] = rx_bus.rx_data;
          csum_d       = csum_q ^ rx_bus.rx_data;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_CSUM;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_IDLE;
          tmo_d      = '0;
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_CSUM: begin
        if (rx_bus.rx_valid) begin
          tmo_d = '0;
          if (rx_bus.rx_data == csum_q) begin
            state_d     = S_HOLD;
            job_valid_d = 1'b1;
          end else begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_IDLE;
          tmo_d      = '0;
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_HOLD: begin
        // Any byte arriving while a job is pending is dropped, ABORT included
        tmo_d = '0;
        if (rx_bus.rx_valid) begin
          overrun_d = 1'b1;
        end
        if (rx_bus.job_ready) begin
          state_d     = S_IDLE;
          job_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        job_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      hdr_q       <= '0;
      job_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      hdr_q       <= hdr_d;
      job_valid_q <= job_valid_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_bus.job_valid  = job_valid_q;
  assign rx_bus.job_header = hdr_q;
  assign rx_bus.abort      = abort_q;
  assign rx_bus.err        = err_q;
  assign rx_bus.err_code   = err_code_q;
  assign rx_bus.overrun    = overrun_q;
endmodule
